jesd204b_rx_link_fsm: RTL
=========================

JESD204B_RX_LINK_FSM -- requirements
Module: jesd204b_rx_link_fsm

Interface
REQ-001 SHALL have parameter LMFC_PERIOD, default 8: i_dclk cycles per local multiframe (K*F/4 for a 4-byte word), legal range 2..256.
REQ-002 SHALL have parameter GT_RESET_CYCLES, default 16: cycles o_gt_reset_all is held high, legal range 1..255.
REQ-003 SHALL have parameter CGS_K_COUNT, default 4: consecutive all-/K/ words needed to declare code group sync, legal range 1..15.
REQ-004 SHALL have parameter ILAS_MF, default 4: multiframes of ILAS skipped before DATA, legal range 1..15.
REQ-005 SHALL have ports:
- i_dclk  in  1: sole clock.
- i_rst  in  1: synchronous, active-high reset.
- i_sysref  in  1: SYSREF, already synchronous to i_dclk.
- i_gt_reset_rx_done  in  1: transceiver RX reset done.
- i_gtpowergood  in  1: transceiver power good.
- i_rxbyteisaligned  in  1: transceiver comma alignment achieved.
- i_rx_data  in  32: received word, byte 0 = [7:0].
- i_rx_charisk  in  4: per-byte K-character flag.
- o_gt_reset_all  out  1: transceiver full reset.
- o_rxpcommaalignen  out  1: plus-comma align enable.
- o_rxmcommaalignen  out  1: minus-comma align enable.
- o_nsync  out  1: JESD204B SYNC~, active low.
- o_lmfc_pulse  out  1: one-cycle pulse at each LMFC boundary.
- o_link_up  out  1: link in DATA state.
- o_data_valid  out  1: i_rx_data is user payload this cycle.
- o_state  out  3: current FSM state encoding.
- o_resync_cnt  out  8: count of link drops and ILAS timeouts.

Function
REQ-006 SHALL implement states GT_RST=0, WAIT_GT=1, CGS=2, CGS_WAIT=3, ILAS=4, DATA=5, reflected on o_state.
REQ-007 SHALL hold o_gt_reset_all=1 in GT_RST for exactly GT_RESET_CYCLES cycles, then enter WAIT_GT.
REQ-008 SHALL leave WAIT_GT for CGS on the first cycle with i_gt_reset_rx_done=1 and i_gtpowergood=1.
REQ-009 SHALL assert both comma align enables only in CGS; in all other states they SHALL be 0.
REQ-010 SHALL define a /K/ word as i_rxbyteisaligned=1, i_rx_charisk=4'hF, and every byte equal to 8'hBC.
REQ-011 In CGS, SHALL increment a consecutive counter on each /K/ word and clear it on any other word; reaching CGS_K_COUNT SHALL enter CGS_WAIT.
REQ-012 SHALL hold o_nsync=0 in every state except ILAS and DATA.
REQ-013 SHALL leave CGS_WAIT for ILAS on the cycle o_lmfc_pulse=1, with o_nsync=1 from the following cycle.
REQ-014 In ILAS, SHALL detect start of ILAS as byte 0 = 8'h1C with i_rx_charisk[0]=1 (/R/).
REQ-015 After /R/, SHALL count ILAS_MF LMFC pulses, then enter DATA on the cycle after the last pulse.
REQ-016 If no /R/ arrives within 4 LMFC pulses of entering ILAS, SHALL return to CGS and increment o_resync_cnt.
REQ-017 In DATA, SHALL drive o_link_up=1 and o_data_valid=1; in all other states both SHALL be 0.
REQ-018 In DATA, a /K/ word or i_rxbyteisaligned=0 SHALL cause return to CGS next cycle and increment o_resync_cnt.
REQ-019 In any state after WAIT_GT, i_gt_reset_rx_done=0 SHALL force GT_RST; this transition SHALL take priority over every other transition.
REQ-020 o_resync_cnt SHALL saturate at 255.
REQ-021 The LMFC counter SHALL count 0..LMFC_PERIOD-1 and wrap; o_lmfc_pulse=1 when the count is 0.

Reset
REQ-022 On i_rst=1 at a clock edge: state=GT_RST with the cycle counter restarted; LMFC counter=0; o_resync_cnt=0; o_nsync=0; o_gt_reset_all=1; comma enables, o_link_up and o_data_valid=0; o_lmfc_pulse=0.
REQ-023 Reset asserted mid-operation, including in DATA, SHALL behave as REQ-022.

Configuration
REQ-024 With macro JESD204B_RX_SYSREF_ALIGN_EN defined, a rising edge of i_sysref SHALL load the LMFC counter with 0 on the next cycle, producing o_lmfc_pulse that cycle. Without it, i_sysref SHALL be ignored and the LMFC counter SHALL run freely from reset.

Verification
REQ-025 Reset release, i_gt_reset_rx_done=1 at cycle 30 -> o_gt_reset_all high for cycles 0..15, state WAIT_GT, then CGS at cycle 31 with comma enables=1.
REQ-026 In CGS, feed 3 /K/ words, 1 data word, then 4 /K/ words -> CGS_WAIT only after the 4th consecutive /K/; o_nsync rises the cycle after the next o_lmfc_pulse.
REQ-027 In ILAS, /R/ then 4 LMFC pulses (LMFC_PERIOD=8) -> DATA 1 cycle after the 4th pulse, o_link_up=1 and o_data_valid=1.
REQ-028 In ILAS, no /R/ for 4 LMFC pulses -> CGS, o_resync_cnt=1, o_nsync=0.
REQ-029 In DATA, one /K/ word -> CGS next cycle, o_nsync=0, o_resync_cnt increments; with i_gt_reset_rx_done dropping in the same cycle -> GT_RST instead.
REQ-030 With JESD204B_RX_SYSREF_ALIGN_EN, i_sysref rising with the LMFC counter at 5 -> o_lmfc_pulse next cycle and every 8 cycles after; without the macro, pulse spacing is unaffected.

Source files
------------

// File: rtl/jesd204b_rx_link_fsm.sv
// JESD204B receive link bring-up controller: GT reset, code group sync, ILAS and DATA tracking.
// Optional JESD204B_RX_SYSREF_ALIGN_EN: a SYSREF rising edge realigns the LMFC counter.
module jesd204b_rx_link_fsm #(
  parameter int LMFC_PERIOD     = 8,
  parameter int GT_RESET_CYCLES = 16,
  parameter int CGS_K_COUNT     = 4,
  parameter int ILAS_MF         = 4
) (
  input  logic        i_dclk,
  input  logic        i_rst,
  input  logic        i_sysref,
  input  logic        i_gt_reset_rx_done,
  input  logic        i_gtpowergood,
  input  logic        i_rxbyteisaligned,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_charisk,
  output logic        o_gt_reset_all,
  output logic        o_rxpcommaalignen,
  output logic        o_rxmcommaalignen,
  output logic        o_nsync,
  output logic        o_lmfc_pulse,
  output logic        o_link_up,
  output logic        o_data_valid,
  output logic [2:0]  o_state,
  output logic [7:0]  o_resync_cnt
);

  // state    | meaning
  // GT_RST   | transceiver held in full reset for GT_RESET_CYCLES
  // WAIT_GT  | waiting for RX reset done and power good
  // CGS      | comma alignment on, counting consecutive /K/ words
  // CGS_WAIT | code group sync reached, waiting for LMFC boundary
  // ILAS     | SYNC~ released, waiting for /R/ then skipping ILAS multiframes
  // DATA     | link up, payload valid
  localparam logic [2:0] ST_GT_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_GT  = 3'd1;
  localparam logic [2:0] ST_CGS      = 3'd2;
  localparam logic [2:0] ST_CGS_WAIT = 3'd3;
  localparam logic [2:0] ST_ILAS     = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;

  localparam logic [7:0] LMFC_LAST    = 8'(LMFC_PERIOD - 1);
  localparam logic [7:0] GT_LAST      = 8'(GT_RESET_CYCLES - 1);
  localparam logic [3:0] K_LAST       = 4'(CGS_K_COUNT - 1);
  localparam logic [3:0] MF_LAST      = 4'(ILAS_MF - 1);
  localparam logic [3:0] ILAS_TO_LAST = 4'd3;

  logic [2:0] state_q, state_d;
  logic [7:0] gt_tmr_q, gt_tmr_d;
  logic [3:0] k_cnt_q, k_cnt_d;
  logic [3:0] mf_cnt_q, mf_cnt_d;
  logic       r_seen_q, r_seen_d;
  logic [7:0] resync_q, resync_d;
  logic [7:0] lmfc_cnt_q, lmfc_cnt_d;
  logic       lmfc_pulse_q;
  logic       resync_bump;
  logic       k_word;
  logic       r_word;
  logic       sysref_rise;

  assign k_word = i_rxbyteisaligned && (i_rx_charisk == 4'hF) && (i_rx_data == 32'hBCBC_BCBC);
  assign r_word = (i_rx_data[7:0] == 8'h1C) && i_rx_charisk[0];

`ifdef JESD204B_RX_SYSREF_ALIGN_EN
  logic sysref_q;

  always_ff @(posedge i_dclk) begin
    if (i_rst) begin
      sysref_q <= 1'b0;
    end else begin
      sysref_q <= i_sysref;
    end
  end

  assign sysref_rise = i_sysref && !sysref_q;
`else
  logic unused_sysref;

  assign unused_sysref = i_sysref;
  assign sysref_rise   = 1'b0;
`endif

  always_comb begin
    lmfc_cnt_d = (lmfc_cnt_q == LMFC_LAST) ? 8'd0 : lmfc_cnt_q + 8'd1;
    if (sysref_rise) begin
      lmfc_cnt_d = 8'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    gt_tmr_d    = gt_tmr_q;
    k_cnt_d     = k_cnt_q;
    mf_cnt_d    = mf_cnt_q;
    r_seen_d    = r_seen_q;
    resync_bump = 1'b0;

    case (state_q)
      ST_GT_RST: begin
        if (gt_tmr_q == 8'd0) begin
          state_d = ST_WAIT_GT;
        end else begin
          gt_tmr_d = gt_tmr_q - 8'd1;
        end
      end
      ST_WAIT_GT: begin
        if (i_gt_reset_rx_done && i_gtpowergood) begin
          state_d = ST_CGS;
          k_cnt_d = 4'd0;
        end
      end
      ST_CGS: begin
        if (k_word) begin
          if (k_cnt_q == K_LAST) begin
            state_d = ST_CGS_WAIT;
          end else begin
            k_cnt_d = k_cnt_q + 4'd1;
          end
        end else begin
          k_cnt_d = 4'd0;
        end
      end
      ST_CGS_WAIT: begin
        if (lmfc_pulse_q) begin
          state_d  = ST_ILAS;
          r_seen_d = 1'b0;
          mf_cnt_d = ILAS_TO_LAST;
        end
      end
      ST_ILAS: begin
        // Only the first /R/ matters; later multiframes also start with /R/.
        if (!r_seen_q) begin
          if (r_word) begin
            r_seen_d = 1'b1;
            mf_cnt_d = MF_LAST;
          end else if (lmfc_pulse_q) begin
            if (mf_cnt_q == 4'd0) begin
              state_d     = ST_CGS;
              k_cnt_d     = 4'd0;
              resync_bump = 1'b1;
            end else begin
              mf_cnt_d = mf_cnt_q - 4'd1;
            end
          end
        end else if (lmfc_pulse_q) begin
          if (mf_cnt_q == 4'd0) begin
            state_d = ST_DATA;
          end else begin
            mf_cnt_d = mf_cnt_q - 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (k_word || !i_rxbyteisaligned) begin
          state_d     = ST_CGS;
          k_cnt_d     = 4'd0;
          resync_bump = 1'b1;
        end
      end
      default: begin
        state_d  = ST_GT_RST;
        gt_tmr_d = GT_LAST;
      end
    endcase

    // Losing the transceiver overrides everything past WAIT_GT.
    if ((state_q != ST_GT_RST) && (state_q != ST_WAIT_GT) && !i_gt_reset_rx_done) begin
      state_d     = ST_GT_RST;
      gt_tmr_d    = GT_LAST;
      resync_bump = 1'b0;
    end

    resync_d = (resync_bump && (resync_q != 8'hFF)) ? resync_q + 8'd1 : resync_q;
  end

  always_ff @(posedge i_dclk) begin
    if (i_rst) begin
      state_q      <= ST_GT_RST;
      gt_tmr_q     <= GT_LAST;
      k_cnt_q      <= 4'd0;
      mf_cnt_q     <= 4'd0;
      r_seen_q     <= 1'b0;
      resync_q     <= 8'd0;
      lmfc_cnt_q   <= 8'd0;
      lmfc_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gt_tmr_q     <= gt_tmr_d;
      k_cnt_q      <= k_cnt_d;
      mf_cnt_q     <= mf_cnt_d;
      r_seen_q     <= r_seen_d;
      resync_q     <= resync_d;
      lmfc_cnt_q   <= lmfc_cnt_d;
      lmfc_pulse_q <= (lmfc_cnt_d == 8'd0);
    end
  end

  assign o_gt_reset_all    = (state_q == ST_GT_RST);
  assign o_rxpcommaalignen = (state_q == ST_CGS);
  assign o_rxmcommaalignen = (state_q == ST_CGS);
  assign o_nsync           = (state_q == ST_ILAS) || (state_q == ST_DATA);
  assign o_link_up         = (state_q == ST_DATA);
  assign o_data_valid      = (state_q == ST_DATA);
  assign o_lmfc_pulse      = lmfc_pulse_q;
  assign o_state           = state_q;
  assign o_resync_cnt      = resync_q;

endmodule
